// File: rtl/mem_arbiter.sv
// Shared memory bus arbiter between instruction fetch and load/store.
// Data has priority; a burst counter lets a waiting fetch through after MAX_DATA_BURST data grants.
module mem_arbiter #(
  parameter int          MAX_DATA_BURST = 2,
  parameter logic [31:0] RESET_DATA     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_cancel,
  output logic        fetch_ready,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_req_t;

  state_t   state, state_nxt;
  logic [3:0] burst_cnt;
  logic     owner_fetch;
  logic     drop;
  logic     fetch_eff, grant_data, grant_fetch, bus_done;
  bus_req_t req_sel;

  always_comb begin
    fetch_eff   = fetch_req && !fetch_cancel;
    grant_data  = data_req && !((burst_cnt == BURST_MAX) && fetch_eff);
    grant_fetch = fetch_eff && !grant_data;
    bus_done    = mem_valid && mem_ready;
    // A fetch never writes; wdata is left as-is since it is meaningless with wstrb=0.
    if (grant_data) req_sel = '{addr: data_addr, we: data_we, wstrb: data_wstrb, wdata: data_wdata};
    else            req_sel = '{addr: fetch_addr, we: 1'b0, wstrb: 4'b0000, wdata: mem_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_fetch) state_nxt = BUSY;
      BUSY:    if (bus_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt   <= 4'd0;
      owner_fetch <= 1'b0;
      drop        <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= RESET_DATA;
      mem_we      <= 1'b0;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= RESET_DATA;
      fetch_ready <= 1'b0;
      fetch_rdata <= RESET_DATA;
      data_ready  <= 1'b0;
      data_rdata  <= RESET_DATA;
    end else begin
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      case (state)
        IDLE: if (grant_data || grant_fetch) begin
          mem_addr    <= req_sel.addr;
          mem_we      <= req_sel.we;
          mem_wstrb   <= req_sel.wstrb;
          mem_wdata   <= req_sel.wdata;
          mem_valid   <= 1'b1;
          owner_fetch <= grant_fetch;
          drop        <= 1'b0;
          if (grant_fetch)                  burst_cnt <= 4'd0;
          else if (burst_cnt != BURST_MAX)  burst_cnt <= burst_cnt + 4'd1;
        end
        BUSY: begin
          if (owner_fetch && fetch_cancel) drop <= 1'b1;
          if (bus_done) begin
            mem_valid <= 1'b0;
            if (owner_fetch) begin
              fetch_rdata <= mem_rdata;
              // A cancel in the completing cycle counts just like an earlier one.
              fetch_ready <= !(drop || fetch_cancel);
            end else begin
              data_rdata <= mem_rdata;
              data_ready <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a wait-state-programmable memory responder.
module tb_mem_arbiter;
  localparam logic [31:0] RST_VAL = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_cancel, fetch_ready;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        data_req, data_we, data_ready;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_valid, mem_we, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  // responder configuration and observations
  int          wait_cfg = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic        force_ready = 1'b0;
  int          fetch_pulses = 0, data_pulses = 0, last_len = 0, unstable = 0;
  logic [31:0] f_addr, f_wdata;
  logic        f_we;
  logic [3:0]  f_wstrb;
  logic [31:0] grant_q[$];

  mem_arbiter #(.MAX_DATA_BURST(2), .RESET_DATA(RST_VAL)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_cancel(fetch_cancel),
    .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: answers after wait_cfg wait cycles, logs grants and bus stability.
  initial begin
    int vcnt;
    vcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (fetch_ready) fetch_pulses++;
      if (data_ready)  data_pulses++;
      if (mem_valid) begin
        if (vcnt == 0) begin
          f_addr = mem_addr; f_we = mem_we; f_wstrb = mem_wstrb; f_wdata = mem_wdata;
          grant_q.push_back(mem_addr);
        end else if (mem_addr !== f_addr || mem_we !== f_we ||
                     mem_wstrb !== f_wstrb || mem_wdata !== f_wdata) begin
          unstable++;
        end
        mem_ready = (vcnt == wait_cfg);
        mem_rdata = rdata_cfg;
        vcnt++;
      end else begin
        if (vcnt != 0) last_len = vcnt;
        vcnt = 0;
        mem_ready = force_ready;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_req = 0; fetch_cancel = 0; fetch_addr = 0;
    data_req = 0; data_we = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    force_ready = 0; wait_cfg = 0;
    tick(); tick();
    reset = 1'b0;
    fetch_pulses = 0; data_pulses = 0; unstable = 0; last_len = 0;
    grant_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({mem_valid, mem_we, mem_wstrb, fetch_ready, data_ready} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000", {mem_valid, mem_we, mem_wstrb, fetch_ready, data_ready});
    end
    total++;
    if (mem_addr !== RST_VAL || mem_wdata !== RST_VAL) begin
      bad++; $display("FAIL reset_bus: addr=%h wdata=%h want %h", mem_addr, mem_wdata, RST_VAL);
    end
    total++;
    if (fetch_rdata !== RST_VAL || data_rdata !== RST_VAL) begin
      bad++; $display("FAIL reset_rdata: f=%h d=%h want %h", fetch_rdata, data_rdata, RST_VAL);
    end
  endtask

  task automatic test_lone_fetch();
    do_reset();
    wait_cfg = 0; rdata_cfg = 32'h0000_0013;
    fetch_req = 1; fetch_addr = 32'h8000_0000;
    tick();
    total++;
    if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8000_0000) begin
      bad++; $display("FAIL fetch_bus: valid=%b we=%b addr=%h want 1 0 80000000", mem_valid, mem_we, mem_addr);
    end
    tick();
    total++;
    if (fetch_ready !== 1'b1 || fetch_rdata !== 32'h0000_0013) begin
      bad++; $display("FAIL fetch_resp: ready=%b rdata=%h want 1 00000013", fetch_ready, fetch_rdata);
    end
    fetch_req = 0;
    tick();
    total++;
    if (fetch_ready !== 1'b0 || mem_valid !== 1'b0 || fetch_rdata !== 32'h0000_0013) begin
      bad++; $display("FAIL fetch_after: ready=%b valid=%b rdata=%h want 0 0 00000013", fetch_ready, mem_valid, fetch_rdata);
    end
    tick(); tick();
    total++;
    if (data_pulses !== 0 || fetch_pulses !== 1) begin
      bad++; $display("FAIL fetch_pulses: data=%0d fetch=%0d want 0 1", data_pulses, fetch_pulses);
    end
  endtask

  task automatic test_store();
    int n;
    do_reset();
    wait_cfg = 3; rdata_cfg = 32'h5555_AAAA;
    data_req = 1; data_we = 1; data_addr = 32'h0000_1000; data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    n = 0;
    while (!data_ready && n < 20) begin tick(); n++; end
    data_req = 0; data_we = 0;
    total++;
    if (!data_ready) begin
      bad++; $display("FAIL store_timeout: ready=%b want 1", data_ready);
    end
    tick(); tick();
    total++;
    if (f_addr !== 32'h0000_1000 || f_we !== 1'b1 || f_wstrb !== 4'b0011 || f_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL store_fields: %h %b %b %h want 00001000 1 0011 deadbeef", f_addr, f_we, f_wstrb, f_wdata);
    end
    total++;
    if (last_len !== 4 || unstable !== 0) begin
      bad++; $display("FAIL store_hold: len=%0d unstable=%0d want 4 0", last_len, unstable);
    end
    total++;
    if (data_pulses !== 1 || fetch_pulses !== 0) begin
      bad++; $display("FAIL store_pulses: data=%0d fetch=%0d want 1 0", data_pulses, fetch_pulses);
    end
  endtask

  task automatic test_burst_order();
    logic [31:0] exp [6];
    exp = '{32'h0000_2000, 32'h0000_2000, 32'h8000_0100, 32'h0000_2000, 32'h0000_2000, 32'h8000_0100};
    do_reset();
    wait_cfg = 0;
    fetch_req = 1; fetch_addr = 32'h8000_0100;
    data_req = 1; data_we = 0; data_addr = 32'h0000_2000;
    repeat (20) tick();
    fetch_req = 0; data_req = 0;
    repeat (5) tick();
    total++;
    if (grant_q.size() < 6) begin
      bad++; $display("FAIL burst_count: grants=%0d want >=6", grant_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (grant_q[i] !== exp[i]) begin
          bad++; $display("FAIL burst_grant%0d: got %h want %h", i, grant_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_cancel();
    int n;
    do_reset();
    wait_cfg = 2; rdata_cfg = 32'hCAFE_0001;
    fetch_req = 1; fetch_addr = 32'h8000_0200;
    tick();
    fetch_req = 0; fetch_cancel = 1;
    tick();
    fetch_cancel = 0;
    n = 0;
    while (mem_valid && n < 10) begin tick(); n++; end
    tick(); tick();
    total++;
    if (mem_valid !== 1'b0 || last_len !== 3) begin
      bad++; $display("FAIL cancel_bus: valid=%b len=%0d want 0 3", mem_valid, last_len);
    end
    total++;
    if (fetch_pulses !== 0) begin
      bad++; $display("FAIL cancel_pulse: fetch=%0d want 0", fetch_pulses);
    end
    wait_cfg = 0; rdata_cfg = 32'h0000_0093;
    fetch_req = 1; fetch_addr = 32'h8000_0300;
    n = 0;
    while (!fetch_ready && n < 10) begin tick(); n++; end
    fetch_req = 0;
    total++;
    if (fetch_ready !== 1'b1 || fetch_rdata !== 32'h0000_0093 || n !== 2) begin
      bad++; $display("FAIL cancel_next: ready=%b rdata=%h cycles=%0d want 1 00000093 2", fetch_ready, fetch_rdata, n);
    end
    tick(); tick();
  endtask

  task automatic test_reset_busy();
    do_reset();
    wait_cfg = 5; rdata_cfg = 32'h7777_0000;
    data_req = 1; data_we = 1; data_addr = 32'h0000_3000; data_wstrb = 4'hF; data_wdata = 32'h0101_0101;
    tick(); tick();
    reset = 1;
    tick();
    total++;
    if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== RST_VAL) begin
      bad++; $display("FAIL rstbusy_bus: valid=%b we=%b strb=%b addr=%h want 0 0 0000 %h", mem_valid, mem_we, mem_wstrb, mem_addr, RST_VAL);
    end
    reset = 0;
    data_we = 0; data_addr = 32'h0000_3004; wait_cfg = 0; rdata_cfg = 32'h4242_4242;
    tick();
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_3004) begin
      bad++; $display("FAIL rstbusy_regrant: valid=%b addr=%h want 1 00003004", mem_valid, mem_addr);
    end
    tick();
    data_req = 0;
    total++;
    if (data_ready !== 1'b1 || data_rdata !== 32'h4242_4242 || data_pulses !== 1) begin
      bad++; $display("FAIL rstbusy_resp: ready=%b rdata=%h pulses=%0d want 1 42424242 1", data_ready, data_rdata, data_pulses);
    end
    tick(); tick();
  endtask

  task automatic test_idle_ready();
    do_reset();
    force_ready = 1;
    repeat (6) tick();
    total++;
    if (mem_valid !== 1'b0 || fetch_pulses !== 0 || data_pulses !== 0) begin
      bad++; $display("FAIL idle_ready: valid=%b f=%0d d=%0d want 0 0 0", mem_valid, fetch_pulses, data_pulses);
    end
    total++;
    if (fetch_rdata !== RST_VAL || data_rdata !== RST_VAL) begin
      bad++; $display("FAIL idle_rdata: f=%h d=%h want %h", fetch_rdata, data_rdata, RST_VAL);
    end
    force_ready = 0;
  endtask

  initial begin
    reset = 1;
    fetch_req = 0; fetch_cancel = 0; fetch_addr = 0;
    data_req = 0; data_we = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    test_reset();
    test_lone_fetch();
    test_store();
    test_burst_order();
    test_cancel();
    test_reset_busy();
    test_idle_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
